// File: rtl/fanout_skid_fifo_pkg.sv
// Shared constants for the fanout skid FIFO: the latencies that size the early-ready slack,
// plus a small helper that classifies each cycle's occupancy update.
package fanout_skid_fifo_pkg;

  localparam int FANOUT_PIPE_LAT = 2;
  localparam int RDY_REG_LAT     = 1;
  localparam int SLACK_DEFAULT   = FANOUT_PIPE_LAT + RDY_REG_LAT;
  localparam int DAT_W_DEFAULT   = 2048;
  localparam int DEPTH_DEFAULT   = 8;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_update_e;

  // A simultaneous write and read cancel out, so only a lone write or a lone read moves the level.
  function automatic lvl_update_e lvl_update(input logic wr, input logic rd);
    lvl_update_e upd;
    upd = LVL_HOLD;
    if (wr && !rd) upd = LVL_INC;
    if (rd && !wr) upd = LVL_DEC;
    return upd;
  endfunction

endpackage

// File: rtl/fanout_skid_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Kept separate so it can be swapped for a LUTRAM/URAM primitive.
module fanout_skid_ram #(
  parameter int dat_w = 2048,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [dat_w-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [dat_w-1:0] rdata
);

  logic [dat_w-1:0] mem [depth];

  // Contents are intentionally not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fanout_skid_fifo.sv
// First-word-fall-through skid FIFO behind the double-fanout stage; a registered early ready
// leaves room for the beats still in flight in the fanout pipeline when the consumer stalls.
module fanout_skid_fifo
  import fanout_skid_fifo_pkg::*;
#(
  parameter int dat_w = DAT_W_DEFAULT,
  parameter int depth = DEPTH_DEFAULT,
  parameter int slack = SLACK_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       up_vld,
  input  logic [dat_w-1:0]           up_dat,
  output logic                       up_rdy,
  output logic                       dn_vld,
  input  logic                       dn_rdy,
  output logic [dat_w-1:0]           dn_dat,
  output logic [$clog2(depth+1)-1:0] lvl,
  output logic                       ovf
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int LW = $clog2(depth + 1);
  localparam logic [LW-1:0] LVL_FULL    = LW'(depth);
  localparam logic [LW-1:0] LVL_RDY_MAX = LW'(depth - slack);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd;
  logic          wr;
  logic          drop;
  logic [LW-1:0] lvl_next;

  assign dn_vld = (lvl != '0);
  assign rd     = dn_vld & dn_rdy;
  assign wr     = up_vld & ((lvl < LVL_FULL) | rd);
  assign drop   = up_vld & (lvl == LVL_FULL) & ~rd;

  always_comb begin
    lvl_next = lvl;
    unique case (lvl_update(wr, rd))
      LVL_INC: lvl_next = lvl + 1'b1;
      LVL_DEC: lvl_next = lvl - 1'b1;
      default: lvl_next = lvl;
    endcase
  end

  // Pointers wrap naturally because depth is a power of two; lvl disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Ready looks at the next level so the fanout sees it one cycle ahead of the actual fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl    <= '0;
      up_rdy <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      lvl    <= lvl_next;
      up_rdy <= (lvl_next <= LVL_RDY_MAX);
      if (drop) ovf <= 1'b1;
    end
  end

  fanout_skid_ram #(
    .dat_w(dat_w),
    .depth(depth),
    .aw   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr),
    .waddr(wr_ptr),
    .wdata(up_dat),
    .raddr(rd_ptr),
    .rdata(dn_dat)
  );

endmodule

// File: tb/tb_fanout_skid_fifo.sv
// Directed bench for fanout_skid_fifo: a queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_fanout_skid_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SLACK = 3;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_vld;
  logic [DW-1:0] up_dat;
  logic          up_rdy;
  logic          dn_vld;
  logic          dn_rdy;
  logic [DW-1:0] dn_dat;
  logic [LW-1:0] lvl;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf    = 1'b0;
  bit            m_rdy    = 1'b1;
  bit            model_on = 1'b0;

  bit            collect = 1'b0;
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fanout_skid_fifo #(
    .dat_w(DW),
    .depth(DEPTH),
    .slack(SLACK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .up_vld(up_vld),
    .up_dat(up_dat),
    .up_rdy(up_rdy),
    .dn_vld(dn_vld),
    .dn_rdy(dn_rdy),
    .dn_dat(dn_dat),
    .lvl   (lvl),
    .ovf   (ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit r);
    up_vld = v;
    up_dat = d;
    dn_rdy = r;
    @(posedge clk);
    #1;
  endtask

  // Model: a plain queue; pops and pushes follow the handshake rules using pre-edge occupancy.
  initial forever begin
    int  pre;
    bit  pop;
    @(posedge clk);
    if (rst_n === 1'b0) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_rdy    = 1'b1;
      model_on = 1'b1;
    end else if (model_on) begin
      pre = mq.size();
      pop = (pre != 0) && (dn_rdy === 1'b1);
      if (pop) void'(mq.pop_front());
      if (up_vld === 1'b1) begin
        if (pre < DEPTH || pop) mq.push_back(up_dat);
        else m_ovf = 1'b1;
      end
      m_rdy = (mq.size() <= DEPTH - SLACK);
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      checkOutput("lvl", 32'(lvl), 32'(mq.size()));
      checkOutput("dn_vld", 32'(dn_vld), 32'(mq.size() != 0));
      checkOutput("up_rdy", 32'(up_rdy), 32'(m_rdy));
      checkOutput("ovf", 32'(ovf), 32'(m_ovf));
      if (mq.size() != 0) checkOutput("dn_dat", dn_dat, mq[0]);
      if (collect && dn_vld === 1'b1 && dn_rdy === 1'b1) out_q.push_back(dn_dat);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int max_lvl;
    rst_n  = 1'b0;
    up_vld = 1'b0;
    up_dat = '0;
    dn_rdy = 1'b0;

    // Reset values
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rst_lvl", 32'(lvl), 0);
    checkOutput("rst_dn_vld", 32'(dn_vld), 0);
    checkOutput("rst_up_rdy", 32'(up_rdy), 1);
    checkOutput("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;

    // Streaming: each beat appears one cycle after its write
    out_q.delete();
    collect = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, DW'(i), 1);
      checkOutput("stream_vld", 32'(dn_vld), 1);
      checkOutput("stream_dat", dn_dat, 32'(i));
      checkOutput("stream_lvl", 32'(lvl), 1);
    end
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    collect = 1'b0;
    checkOutput("stream_cnt", 32'(out_q.size()), 8);
    for (int i = 0; i < 8 && i < out_q.size(); i++)
      checkOutput("stream_order", out_q[i], 32'(i + 1));
    checkOutput("stream_ovf", 32'(ovf), 0);

    // Stall: fanout keeps sending for 2 cycles after ready drops
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, DW'(32'h10 + k), 0);
      if (k == 4) begin
        checkOutput("stall_lvl5", 32'(lvl), 5);
        checkOutput("stall_rdy5", 32'(up_rdy), 1);
      end
      if (k == 5) begin
        checkOutput("stall_lvl6", 32'(lvl), 6);
        checkOutput("stall_rdy6", 32'(up_rdy), 0);
      end
    end
    checkOutput("stall_lvl8", 32'(lvl), 8);
    checkOutput("stall_rdy8", 32'(up_rdy), 0);
    checkOutput("stall_ovf", 32'(ovf), 0);

    // Full with simultaneous read and write, then full with a drop
    out_q.delete();
    collect = 1'b1;
    applyStimulus(1, 32'h99, 1);
    checkOutput("full_rw_lvl", 32'(lvl), 8);
    checkOutput("full_rw_ovf", 32'(ovf), 0);
    checkOutput("full_rw_head", dn_dat, 32'h11);
    applyStimulus(1, 32'hEE, 0);
    checkOutput("drop_lvl", 32'(lvl), 8);
    checkOutput("drop_ovf", 32'(ovf), 1);
    repeat (10) applyStimulus(0, 0, 1);
    collect = 1'b0;
    checkOutput("drain_lvl", 32'(lvl), 0);
    checkOutput("drain_ovf_sticky", 32'(ovf), 1);
    checkOutput("drain_rdy", 32'(up_rdy), 1);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(DW'(32'h10 + k));
    exp_q.push_back(32'h99);
    checkOutput("drain_cnt", 32'(out_q.size()), 9);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      checkOutput("drain_order", out_q[i], exp_q[i]);

    // Pointer wrap with random consumer stalls
    out_q.delete();
    exp_q.delete();
    collect = 1'b1;
    sent    = 0;
    max_lvl = 0;
    for (int c = 0; c < 300 && sent < 20; c++) begin
      if (mq.size() < 6) begin
        exp_q.push_back(DW'(32'h100 + sent));
        applyStimulus(1, DW'(32'h100 + sent), 1'($urandom_range(0, 1)));
        sent++;
      end else begin
        applyStimulus(0, 0, 1'($urandom_range(0, 1)));
      end
      if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
    end
    repeat (12) applyStimulus(0, 0, 1);
    collect = 1'b0;
    checkOutput("wrap_sent", 32'(sent), 20);
    checkOutput("wrap_cnt", 32'(out_q.size()), 20);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      checkOutput("wrap_order", out_q[i], exp_q[i]);
    checkOutput("wrap_max_lvl_ok", 32'(max_lvl <= 8), 1);
    checkOutput("wrap_ovf_sticky", 32'(ovf), 1);

    // Reset mid-operation discards everything
    for (int k = 0; k < 5; k++) applyStimulus(1, DW'(32'h200 + k), 0);
    checkOutput("pre_rst_lvl", 32'(lvl), 5);
    rst_n = 1'b0;
    applyStimulus(1, 32'h3C, 0);
    checkOutput("mid_rst_lvl", 32'(lvl), 0);
    checkOutput("mid_rst_vld", 32'(dn_vld), 0);
    checkOutput("mid_rst_rdy", 32'(up_rdy), 1);
    checkOutput("mid_rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    applyStimulus(1, 32'hA5, 0);
    checkOutput("post_rst_lvl", 32'(lvl), 1);
    checkOutput("post_rst_vld", 32'(dn_vld), 1);
    checkOutput("post_rst_dat", dn_dat, 32'hA5);
    applyStimulus(0, 0, 1);
    checkOutput("post_rst_empty", 32'(lvl), 0);
    applyStimulus(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
